alu_cmd_queue: RTL and testbench
================================

Name: alu_cmd_queue

Overview:
- Operand/command front end sitting directly upstream of the 4-bit ALU plus 8-bit accumulator register.
- Buffers up to DEPTH user-entered commands, each a 3-bit function select and a 4-bit A operand.
- On each step request, pops one command and presents it to the ALU with a one-cycle exec pulse that enables the accumulator load.
- Replaces direct switch-to-ALU wiring so that a sequence of operations can be queued, then executed one step at a time.

Parameters:
- DEPTH, 4, number of command entries; power of 2, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push_key  input  1  level, active-high (already inverted from the key); a rising edge enqueues cmd_in.
- step_key  input  1  level, active-high; a rising edge dequeues one command.
- cmd_in  input  7  {func[2:0], a[3:0]}, sampled in the push cycle.
- op_a  output  4  A operand to the ALU (registered).
- op_func  output  3  function select to the ALU (registered).
- exec  output  1  one-cycle pulse; the accumulator loads when it is high.
- count  output  PTR_W+1  number of stored entries, 0..DEPTH.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.
- overflow  output  1  sticky; set by a push that is dropped.
- underflow  output  1  sticky; set by a step that is ignored.

Behaviour:
- Reset (synchronous, active-high; dominates every other input in that cycle):
  - Pointers cleared; count=0, empty=1, full=0.
  - op_a=0, op_func=0, exec=0, overflow=0, underflow=0.
  - Edge-detect history registers set to 1, so a key held through reset does not produce a pulse.
  - Storage array contents are don't-care.
- Edge detect:
  - push_p = push_key & ~push_q; step_p = step_key & ~step_q.
  - push_q and step_q are registered copies of the keys, updated every non-reset cycle.
  - A key held high gives exactly one pulse. A new pulse requires the key to drop low for at least one cycle.
- Push:
  - When push_p is high and the queue is not full (or a pop occurs in the same cycle), mem[wr_ptr] <= cmd_in and wr_ptr increments.
  - wr_ptr wraps modulo DEPTH.
- Pop:
  - When step_p is high and count!=0, the following happen at the next edge:
    - {op_func, op_a} <= mem[rd_ptr].
    - rd_ptr increments, wrapping modulo DEPTH.
    - exec <= 1.
  - Latency: the key rises in cycle n; op_a, op_func and exec change at edge n+1; exec is high for exactly one cycle.
  - op_a and op_func hold their values until the next pop.
- count:
  - +1 on push only, -1 on pop only, unchanged when both or neither occur.
  - full and empty are decoded combinationally from count.
- Boundary conditions:
  - Push while full, no pop: cmd_in dropped, overflow <= 1, state otherwise unchanged.
  - Step while empty: ignored, underflow <= 1, exec stays 0. This holds even if a push occurs in the same cycle; that push is stored and count becomes 1.
  - Push and step in the same cycle when full: both performed. The popped entry is the old head, the new entry is written into the freed slot, count stays DEPTH, no overflow.
  - Push and step in the same cycle with 0<count<DEPTH: both performed, count unchanged.
  - Flags overflow and underflow clear only on reset.
  - Reset asserted in the same cycle as a pop: no exec, outputs return to 0.
- There is no bypass: an entry pushed in cycle n can be popped at the earliest by a step in cycle n+1.

Test Plan:
- Reset, then push {3'b111,4'h3}, then step → op_func=7, op_a=3, exec high for exactly 1 cycle, count 1→0, empty=1.
- Push four commands A=1,2,3,4 (func 6) → full=1, count=4. A fifth push of A=5 → overflow=1, count=4. Four steps → op_a sequence 1,2,3,4, and A=5 never appears.
- Step while empty → exec=0, underflow=1, op_a and op_func unchanged. A later push followed by a step works normally.
- Hold push_key high for 10 cycles → exactly one entry stored (count=1).
- With the queue full (A=1..4), push A=9 and step in the same cycle → op_a=1, count=4, overflow=0. The following steps yield 2,3,4,9 (pointer wrap-around).
- Push 2 entries, assert reset in the same cycle as a step → count=0, exec=0, op_a=0. A key held high across reset release produces no pulse.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the 4-bit ALU: rising edges on push_key enqueue
// {func, a}, rising edges on step_key pop one entry and pulse exec.
module alu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_key,
  input  logic             step_key,
  input  logic [6:0]       cmd_in,
  output logic [3:0]       op_a,
  output logic [2:0]       op_func,
  output logic             exec,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [6:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [2:0]       op_func_q, op_func_d;
  logic             exec_q, exec_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             push_key_q, step_key_q;
  logic             push_p, step_p, do_push, do_pop, is_empty, is_full;

  always_comb begin
    push_p   = push_key & ~push_key_q;
    step_p   = step_key & ~step_key_q;
    is_empty = (count_q == '0);
    is_full  = (count_q == FULL_CNT);
    do_pop   = step_p & ~is_empty;
    // A simultaneous pop frees the head slot, so a push into a full queue still fits.
    do_push  = push_p & (~is_full | do_pop);

    wr_ptr_d    = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (do_pop && !do_push) count_d = count_q - CNT_ONE;

    op_a_d      = op_a_q;
    op_func_d   = op_func_q;
    if (do_pop) {op_func_d, op_a_d} = mem_q[rd_ptr_q];
    exec_d      = do_pop;
    overflow_d  = overflow_q  | (push_p & ~do_push);
    underflow_d = underflow_q | (step_p & is_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_a_q      <= '0;
      op_func_q   <= '0;
      exec_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      // Held keys must not look like fresh presses once reset releases.
      push_key_q  <= 1'b1;
      step_key_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op_a_q      <= op_a_d;
      op_func_q   <= op_func_d;
      exec_q      <= exec_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      push_key_q  <= push_key;
      step_key_q  <= step_key;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= cmd_in;
  end

  assign op_a      = op_a_q;
  assign op_func   = op_func_q;
  assign exec      = exec_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push_key = 1'b0;
  logic       step_key = 1'b0;
  logic [6:0] cmd_in = '0;
  logic [3:0] op_a;
  logic [2:0] op_func;
  logic       exec;
  logic [2:0] count;
  logic       empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  alu_cmd_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .push_key(push_key), .step_key(step_key),
    .cmd_in(cmd_in), .op_a(op_a), .op_func(op_func), .exec(exec),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push_key = 1'b0;
    step_key = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press_push(input logic [6:0] cmd);
    cmd_in = cmd;
    push_key = 1'b1;
    tick();
    push_key = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if ({op_func, op_a} !== 7'h00) begin errors++; $display("FAIL reset_ops got %h exp 00", {op_func, op_a}); end
    checks++; if ({exec, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {exec, overflow, underflow}); end
  endtask

  task automatic test_single();
    do_reset();
    press_push({3'd7, 4'h3});
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_push got %0d exp 1", count); end
    step_key = 1'b1;
    tick();
    checks++; if (exec !== 1'b1) begin errors++; $display("FAIL single_exec got %b exp 1", exec); end
    checks++; if (op_func !== 3'd7 || op_a !== 4'h3) begin errors++; $display("FAIL single_ops got %0d/%h exp 7/3", op_func, op_a); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_empty got count %0d empty %b exp 0/1", count, empty); end
    step_key = 1'b0;
    tick();
    checks++; if (exec !== 1'b0) begin errors++; $display("FAIL single_exec_width got %b exp 0", exec); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) press_push({3'd6, 4'(i)});
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_full got full %b count %0d exp 1/4", full, count); end
    press_push({3'd6, 4'h5});
    checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_flag got ovf %b count %0d exp 1/4", overflow, count); end
    for (int i = 1; i <= 4; i++) begin
      step_key = 1'b1;
      tick();
      checks++; if (exec !== 1'b1 || op_a !== 4'(i) || op_func !== 3'd6) begin errors++; $display("FAIL ovf_pop%0d got exec %b op %0d/%h exp 1 6/%h", i, exec, op_func, op_a, 4'(i)); end
      step_key = 1'b0;
      tick();
    end
    checks++; if (empty !== 1'b1 || op_a !== 4'h4) begin errors++; $display("FAIL ovf_drained got empty %b op_a %h exp 1/4", empty, op_a); end
  endtask

  task automatic test_underflow();
    do_reset();
    press_push({3'd2, 4'hA});
    step_key = 1'b1; tick(); step_key = 1'b0; tick();
    step_key = 1'b1;
    tick();
    checks++; if (exec !== 1'b0 || underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got exec %b udf %b exp 0/1", exec, underflow); end
    checks++; if (op_func !== 3'd2 || op_a !== 4'hA) begin errors++; $display("FAIL udf_hold got %0d/%h exp 2/a", op_func, op_a); end
    step_key = 1'b0;
    tick();
    press_push({3'd5, 4'hC});
    step_key = 1'b1;
    tick();
    checks++; if (exec !== 1'b1 || op_func !== 3'd5 || op_a !== 4'hC) begin errors++; $display("FAIL udf_recover got exec %b op %0d/%h exp 1 5/c", exec, op_func, op_a); end
    step_key = 1'b0;
    tick();
    // Push and step together while empty: push stored, step ignored.
    cmd_in = {3'd1, 4'hE};
    push_key = 1'b1;
    step_key = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || exec !== 1'b0) begin errors++; $display("FAIL udf_simul got count %0d exec %b exp 1/0", count, exec); end
    push_key = 1'b0;
    step_key = 1'b0;
    tick();
    step_key = 1'b1;
    tick();
    checks++; if (exec !== 1'b1 || op_a !== 4'hE) begin errors++; $display("FAIL udf_simul_pop got exec %b op_a %h exp 1/e", exec, op_a); end
    step_key = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    cmd_in = {3'd3, 4'h8};
    push_key = 1'b1;
    repeat (10) tick();
    push_key = 1'b0;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL hold_count got %0d exp 1", count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'h2; exp_seq[1] = 4'h3; exp_seq[2] = 4'h4; exp_seq[3] = 4'h9;
    do_reset();
    for (int i = 1; i <= 4; i++) press_push({3'd6, 4'(i)});
    cmd_in = {3'd6, 4'h9};
    push_key = 1'b1;
    step_key = 1'b1;
    tick();
    checks++; if (exec !== 1'b1 || op_a !== 4'h1) begin errors++; $display("FAIL b2b_pop got exec %b op_a %h exp 1/1", exec, op_a); end
    checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_state got count %0d full %b ovf %b exp 4/1/0", count, full, overflow); end
    push_key = 1'b0;
    step_key = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      step_key = 1'b1;
      tick();
      checks++; if (exec !== 1'b1 || op_a !== exp_seq[i]) begin errors++; $display("FAIL b2b_wrap%0d got exec %b op_a %h exp 1/%h", i, exec, op_a, exp_seq[i]); end
      step_key = 1'b0;
      tick();
    end
    // Mid-depth simultaneous push/pop keeps count unchanged.
    press_push({3'd1, 4'h6});
    press_push({3'd2, 4'h7});
    cmd_in = {3'd3, 4'hB};
    push_key = 1'b1;
    step_key = 1'b1;
    tick();
    checks++; if (count !== 3'd2 || op_a !== 4'h6 || op_func !== 3'd1) begin errors++; $display("FAIL b2b_mid got count %0d op %0d/%h exp 2 1/6", count, op_func, op_a); end
    push_key = 1'b0;
    step_key = 1'b0;
    tick();
  endtask

  task automatic test_reset_pop();
    do_reset();
    press_push({3'd4, 4'h7});
    press_push({3'd4, 4'h8});
    step_key = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (exec !== 1'b0 || count !== 3'd0 || op_a !== 4'h0 || op_func !== 3'd0) begin errors++; $display("FAIL rstpop got exec %b count %0d op %0d/%h exp 0 0 0/0", exec, count, op_func, op_a); end
    push_key = 1'b1;
    cmd_in = {3'd5, 4'h5};
    reset = 1'b0;
    tick();
    tick();
    checks++; if (count !== 3'd0 || exec !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_held got count %0d exec %b udf %b exp 0/0/0", count, exec, underflow); end
    push_key = 1'b0;
    step_key = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_underflow();
    test_hold();
    test_back_to_back();
    test_reset_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
